sprite_mover: RTL and testbench
===============================

# sprite_mover

Multi-sprite motion controller for the pixel domain. It holds position and signed velocity for `SPR_CNT` sprites and advances every sprite once per `frame` pulse, in both axes. Each edge either bounces or wraps. It generalises the single-sprite, horizontal-only bounce logic used in the hardware-sprite demos. Its packed position outputs feed one `sprite` instance per sprite.

## Interface
Parameters:
- `CORDW`, 16: signed coordinate width.
- `SPR_CNT`, 4: number of sprites (1–16).
- `H_RES`, 640: horizontal resolution.
- `V_RES`, 480: vertical resolution.
- `SPR_DRAWW`, 64: drawn sprite width in pixels.
- `SPR_DRAWH`, 64: drawn sprite height in pixels.
- `VELW`, 6: signed velocity width.
- `SPR_SPX`, 4: reset velocity for both axes.

Ports:
- `clk_pix` in 1: pixel clock.
- `rst_pix` in 1: synchronous, active-high reset.
- `frame` in 1: one-cycle start-of-frame strobe.
- `pause` in 1: while high, `frame` is ignored.
- `wrap` in 1: edge mode; 0 = bounce, 1 = wrap. Only used when `SPRITE_MOVER_WRAP_EN` is defined.
- `ld_valid` in 1: load request.
- `ld_ready` out 1: equals `!busy`.
- `ld_idx` in `$clog2(SPR_CNT)` (min 1): sprite to load.
- `ld_x`, `ld_y` in `CORDW` signed: loaded position.
- `ld_vx`, `ld_vy` in `VELW` signed: loaded velocity.
- `sprx`, `spry` out `SPR_CNT*CORDW`: packed positions; sprite i is at bits `[i*CORDW +: CORDW]`.
- `busy` out 1: update sweep in progress.
- `done` out 1: one-cycle pulse when the sweep completes.

## Operation
State machine: IDLE → UPDATE → IDLE. A counter `idx` runs from 0 to SPR_CNT−1.

- **IDLE:** `frame && !pause` → UPDATE with `idx = 0`.
- **UPDATE:** one sprite is updated per cycle: nx = x+vx, ny = y+vy, both sign-extended to `CORDW`.
  - After `idx = SPR_CNT−1`, return to IDLE and pulse `done`.
- **Bounce mode:**
  - If nx > H_RES−SPR_DRAWW: x ← H_RES−SPR_DRAWW, vx ← −vx.
  - If nx < 0: x ← 0, vx ← −vx.
  - Otherwise x ← nx.
  - The Y axis behaves the same, using V_RES and SPR_DRAWH.
- **Wrap mode:**
  - If nx ≥ H_RES: x ← nx−(H_RES+SPR_DRAWW).
  - If nx < −SPR_DRAWW: x ← nx+(H_RES+SPR_DRAWW).
  - Otherwise x ← nx.
  - The Y axis behaves the same, using V_RES and SPR_DRAWH.
  - Velocity is unchanged.
- **Loads:** a load writes all four fields of `ld_idx` when `ld_valid && ld_ready`.
  - `ld_idx` ≥ SPR_CNT is ignored.
  - `ld_valid` while busy is dropped, not queued.
- **Velocity rules:** |v| must be < min(SPR_DRAWW, SPR_DRAWH). Negating −2^(VELW−1) saturates to 2^(VELW−1)−1.

## Timing
- **Reset values:** state IDLE, `busy`=0, `done`=0, and for each sprite i:
  - sprx[i] = i*SPR_DRAWW.
  - spry[i] = V_RES/2−SPR_DRAWH/2.
  - vx = vy = +SPR_SPX.
- **Sweep latency:** `frame` sampled at cycle 0 → `busy` high cycles 1..SPR_CNT.
  - Sprite i's output changes at the edge ending cycle i+1.
  - `done` is high in cycle SPR_CNT+1.
  - Total latency is SPR_CNT+1 cycles.
- **Frame while busy:** `frame` arriving while busy is ignored.
- **Load and frame together in IDLE:** both are accepted. The load is written at that edge, and the sweep uses the loaded values.
- **Reset mid-sweep:** `rst_pix` aborts the sweep, restores reset values, and suppresses `done`.
- **Mode changes:** `wrap` is sampled per sprite during the sweep. Changing it mid-sweep is legal, and the sprites are then handled in mixed modes.

## Configuration
- `SPRITE_MOVER_WRAP_EN` defined: wrap mode is available via the `wrap` port.
- `SPRITE_MOVER_WRAP_EN` undefined: the `wrap` port remains but is ignored, all edges bounce, and wrap logic is not synthesised.

## Test plan
- **Reset defaults** (default params): assert reset, then release. Expect sprx = {192,128,64,0} (MSB→LSB sprite order), spry all 208, `busy`=0, `done`=0.
- **Sweep timing** (SPR_CNT=4): one `frame` pulse. Expect `busy` high for 4 cycles, `done` in cycle 5, every sprx +4 and spry +4. A second `frame` during busy changes nothing.
- **Right-edge bounce:** load sprite 0 with x=574, vx=+4, then `frame`. Expect x=576 and vx=−4. The next frame gives x=572.
- **Left-edge wrap** (macro on, `wrap`=1): load x=−62, vx=−4, then `frame`. Expect x=638, since −66+704=638.
  - Same stimulus with the macro off: expect x=0, vx=+4.
- **Pause and load gating:** with `pause`=1, send 3 frames. Expect no position change and no `done`. Assert `ld_valid` during a sweep: expect it ignored and `ld_ready`=0.
- **Reset mid-sweep:** assert reset in sweep cycle 2. Expect all sprites at reset values and no `done` pulse.

Source files
------------

// File: rtl/sprite_mover.sv
// rtl/sprite_mover.sv - multi-sprite position/velocity sweep with bounce or wrap edges
// Define SPRITE_MOVER_WRAP_EN to enable wrap mode through the wrap port.
module sprite_mover #(
  parameter int CORDW     = 16,
  parameter int SPR_CNT   = 4,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int SPR_DRAWW = 64,
  parameter int SPR_DRAWH = 64,
  parameter int VELW      = 6,
  parameter int SPR_SPX   = 4,
  localparam int IDXW     = (SPR_CNT > 1) ? $clog2(SPR_CNT) : 1
) (
  input  logic                      clk_pix,
  input  logic                      rst_pix,
  input  logic                      frame,
  input  logic                      pause,
  input  logic                      wrap,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [IDXW-1:0]           ld_idx,
  input  logic signed [CORDW-1:0]   ld_x,
  input  logic signed [CORDW-1:0]   ld_y,
  input  logic signed [VELW-1:0]    ld_vx,
  input  logic signed [VELW-1:0]    ld_vy,
  output logic [SPR_CNT*CORDW-1:0]  sprx,
  output logic [SPR_CNT*CORDW-1:0]  spry,
  output logic                      busy,
  output logic                      done
);

  localparam logic signed [CORDW-1:0] X_RES  = CORDW'(H_RES);
  localparam logic signed [CORDW-1:0] Y_RES  = CORDW'(V_RES);
  localparam logic signed [CORDW-1:0] X_DRAW = CORDW'(SPR_DRAWW);
  localparam logic signed [CORDW-1:0] Y_DRAW = CORDW'(SPR_DRAWH);
  localparam logic signed [CORDW-1:0] Y_RST  = CORDW'(V_RES / 2 - SPR_DRAWH / 2);
  localparam logic signed [VELW-1:0]  V_RST  = VELW'(SPR_SPX);
  localparam logic signed [VELW-1:0]  V_MIN  = {1'b1, {(VELW-1){1'b0}}};
  localparam logic signed [VELW-1:0]  V_MAX  = {1'b0, {(VELW-1){1'b1}}};
  localparam logic [IDXW-1:0]         IDX_LAST = IDXW'(SPR_CNT - 1);

  typedef enum logic [0:0] {IDLE, UPDATE} state_t;

  typedef struct packed {
    logic signed [CORDW-1:0] pos;
    logic signed [VELW-1:0]  vel;
  } axis_t;

  // Negating the most negative velocity would overflow, so it clips to the max.
  function automatic logic signed [VELW-1:0] neg_sat(input logic signed [VELW-1:0] v);
    if (v == V_MIN) return V_MAX;
    return -v;
  endfunction

  function automatic axis_t axis_step(
    input logic signed [CORDW-1:0] pos,
    input logic signed [VELW-1:0]  vel,
    input logic signed [CORDW-1:0] res,
    input logic signed [CORDW-1:0] draw,
    input logic                    wrap_mode
  );
    logic signed [CORDW-1:0] np;
    logic signed [CORDW-1:0] lim;
    logic signed [CORDW-1:0] span;
    axis_t r;
    np    = pos + {{(CORDW-VELW){vel[VELW-1]}}, vel};
    lim   = res - draw;
    span  = res + draw;
    r.pos = np;
    r.vel = vel;
    if (wrap_mode) begin
      if (np >= res) begin
        r.pos = np - span;
      end else if (np < -draw) begin
        r.pos = np + span;
      end
    end else begin
      if (np > lim) begin
        r.pos = lim;
        r.vel = neg_sat(vel);
      end else if (np[CORDW-1]) begin
        r.pos = '0;
        r.vel = neg_sat(vel);
      end
    end
    return r;
  endfunction

  logic wrap_sel;
`ifdef SPRITE_MOVER_WRAP_EN
  assign wrap_sel = wrap;
`else
  logic unused_wrap;
  assign unused_wrap = wrap;
  assign wrap_sel    = 1'b0;
`endif

  state_t                  state_q;
  logic [IDXW-1:0]         idx_q;
  logic                    busy_q;
  logic                    done_q;
  logic signed [CORDW-1:0] x_q  [SPR_CNT];
  logic signed [CORDW-1:0] y_q  [SPR_CNT];
  logic signed [VELW-1:0]  vx_q [SPR_CNT];
  logic signed [VELW-1:0]  vy_q [SPR_CNT];

  axis_t hstep_d;
  axis_t vstep_d;
  logic  ld_idx_ok;

  assign ld_idx_ok = (32'(ld_idx) < 32'(SPR_CNT));

  always_comb begin
    hstep_d = axis_step(x_q[idx_q], vx_q[idx_q], X_RES, X_DRAW, wrap_sel);
    vstep_d = axis_step(y_q[idx_q], vy_q[idx_q], Y_RES, Y_DRAW, wrap_sel);
  end

  // Loads are only taken in IDLE, which is exactly when ld_ready is high.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < SPR_CNT; i++) begin
        x_q[i]  <= CORDW'(i * SPR_DRAWW);
        y_q[i]  <= Y_RST;
        vx_q[i] <= V_RST;
        vy_q[i] <= V_RST;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ld_valid && ld_idx_ok) begin
            x_q[ld_idx]  <= ld_x;
            y_q[ld_idx]  <= ld_y;
            vx_q[ld_idx] <= ld_vx;
            vy_q[ld_idx] <= ld_vy;
          end
          if (frame && !pause) begin
            state_q <= UPDATE;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        UPDATE: begin
          x_q[idx_q]  <= hstep_d.pos;
          vx_q[idx_q] <= hstep_d.vel;
          y_q[idx_q]  <= vstep_d.pos;
          vy_q[idx_q] <= vstep_d.vel;
          if (idx_q == IDX_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < SPR_CNT; g++) begin : g_out
    assign sprx[g*CORDW +: CORDW] = x_q[g];
    assign spry[g*CORDW +: CORDW] = y_q[g];
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ld_ready = !busy_q;

endmodule

// File: tb/tb_sprite_mover.sv
// tb/tb_sprite_mover.sv - randomized self-checking bench for sprite_mover
// Expected wrap behaviour follows SPRITE_MOVER_WRAP_EN as seen by the bench.
module tb_sprite_mover;
  localparam int CORDW   = 16;
  localparam int SPR_CNT = 4;
  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int DW      = 64;
  localparam int DH      = 64;
  localparam int VELW    = 6;
  localparam int IDXW    = 2;

  logic clk_pix = 1'b0;
  logic rst_pix, frame, pause, wrap, ld_valid, ld_ready, busy, done;
  logic [IDXW-1:0] ld_idx;
  logic signed [CORDW-1:0] ld_x, ld_y;
  logic signed [VELW-1:0] ld_vx, ld_vy;
  logic [SPR_CNT*CORDW-1:0] sprx, spry;

  int n_tests = 0;
  int n_fail  = 0;
  int mx[SPR_CNT], my[SPR_CNT], mvx[SPR_CNT], mvy[SPR_CNT];
  bit wrap_on;

  sprite_mover dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .frame(frame), .pause(pause), .wrap(wrap),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_idx(ld_idx), .ld_x(ld_x), .ld_y(ld_y),
    .ld_vx(ld_vx), .ld_vy(ld_vy), .sprx(sprx), .spry(spry), .busy(busy), .done(done)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  function automatic int dut_x(int i);
    return int'($signed(sprx[i*CORDW +: CORDW]));
  endfunction

  function automatic int dut_y(int i);
    return int'($signed(spry[i*CORDW +: CORDW]));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SPR_CNT; i++) begin
      mx[i] = i * DW; my[i] = V_RES / 2 - DH / 2; mvx[i] = 4; mvy[i] = 4;
    end
  endtask

  task automatic model_axis(input int p, input int v, input int res, input int draw, input bit wr,
                            output int np, output int nv);
    np = p + v;
    nv = v;
    if (wr) begin
      if (np >= res) np -= res + draw;
      else if (np < -draw) np += res + draw;
    end else if (np > res - draw || np < 0) begin
      np = (np < 0) ? 0 : res - draw;
      nv = (v == -(1 << (VELW-1))) ? (1 << (VELW-1)) - 1 : -v;
    end
  endtask

  task automatic model_frame();
    bit wr;
    wr = wrap_on && wrap;
    for (int i = 0; i < SPR_CNT; i++) begin
      model_axis(mx[i], mvx[i], H_RES, DW, wr, mx[i], mvx[i]);
      model_axis(my[i], mvy[i], V_RES, DH, wr, my[i], mvy[i]);
    end
  endtask

  task automatic do_load(input int idx, input int x, input int y, input int vx, input int vy);
    ld_idx = IDXW'(idx); ld_x = CORDW'(x); ld_y = CORDW'(y);
    ld_vx = VELW'(vx); ld_vy = VELW'(vy); ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
    mx[idx] = x; my[idx] = y; mvx[idx] = vx; mvy[idx] = vy;
  endtask

  task automatic run_frame();
    int k;
    frame = 1'b1;
    tick();
    frame = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 20) begin tick(); k++; end
    n_tests++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL frame_timeout done=%b required=1", done); end
    model_frame();
  endtask

  task automatic test_reset();
    rst_pix = 1'b1;
    tick(); tick();
    rst_pix = 1'b0;
    tick();
    for (int i = 0; i < SPR_CNT; i++) begin
      n_tests++;
      if (dut_x(i) !== i * 64 || dut_y(i) !== 208) begin
        n_fail++;
        $display("FAIL reset_pos[%0d] got x=%0d y=%0d required x=%0d y=208", i, dut_x(i), dut_y(i), i * 64);
      end
    end
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || ld_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_flags busy=%b done=%b ld_ready=%b required 0 0 1", busy, done, ld_ready);
    end
    model_reset();
  endtask

  task automatic test_sweep_timing();
    int ox[SPR_CNT], oy[SPR_CNT];
    int upd, ex, ey;
    wrap = 1'b0;
    for (int i = 0; i < SPR_CNT; i++) begin ox[i] = mx[i]; oy[i] = my[i]; end
    model_frame();
    frame = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      frame = (k == 2);
      upd = (k - 1 < SPR_CNT) ? k - 1 : SPR_CNT;
      n_tests++;
      if (busy !== (k <= SPR_CNT) || done !== (k == SPR_CNT + 1) || ld_ready !== !(k <= SPR_CNT)) begin
        n_fail++;
        $display("FAIL sweep_flags cycle=%0d got busy=%b done=%b ld_ready=%b required busy=%0d done=%0d",
                 k, busy, done, ld_ready, k <= SPR_CNT, k == SPR_CNT + 1);
      end
      for (int i = 0; i < SPR_CNT; i++) begin
        ex = (i < upd) ? mx[i] : ox[i];
        ey = (i < upd) ? my[i] : oy[i];
        n_tests++;
        if (dut_x(i) !== ex || dut_y(i) !== ey) begin
          n_fail++;
          $display("FAIL sweep_pos cycle=%0d spr=%0d got (%0d,%0d) required (%0d,%0d)",
                   k, i, dut_x(i), dut_y(i), ex, ey);
        end
      end
    end
    frame = 1'b0;
  endtask

  task automatic test_bounce_right();
    wrap = 1'b0;
    do_load(0, 574, 100, 4, 0);
    run_frame();
    n_tests++;
    if (dut_x(0) !== 576) begin n_fail++; $display("FAIL bounce_right_1 got x=%0d required 576", dut_x(0)); end
    run_frame();
    n_tests++;
    if (dut_x(0) !== 572) begin n_fail++; $display("FAIL bounce_right_2 got x=%0d required 572", dut_x(0)); end
    for (int i = 1; i < SPR_CNT; i++) begin
      n_tests++;
      if (dut_x(i) !== mx[i] || dut_y(i) !== my[i]) begin
        n_fail++;
        $display("FAIL bounce_others spr=%0d got (%0d,%0d) required (%0d,%0d)", i, dut_x(i), dut_y(i), mx[i], my[i]);
      end
    end
  endtask

  task automatic test_left_edge();
    int e1, e2;
    e1 = wrap_on ? 638 : 0;
    e2 = wrap_on ? 634 : 4;
    wrap = 1'b1;
    do_load(0, -62, 100, -4, 0);
    run_frame();
    n_tests++;
    if (dut_x(0) !== e1) begin n_fail++; $display("FAIL left_edge_1 got x=%0d required %0d", dut_x(0), e1); end
    run_frame();
    n_tests++;
    if (dut_x(0) !== e2) begin n_fail++; $display("FAIL left_edge_2 got x=%0d required %0d", dut_x(0), e2); end
    wrap = 1'b0;
  endtask

  task automatic test_load_with_frame();
    int k;
    ld_idx = 2'd2; ld_x = 16'sd300; ld_y = 16'sd50; ld_vx = -6'sd7; ld_vy = 6'sd5;
    ld_valid = 1'b1;
    frame = 1'b1;
    tick();
    ld_valid = 1'b0;
    frame = 1'b0;
    mx[2] = 300; my[2] = 50; mvx[2] = -7; mvy[2] = 5;
    model_frame();
    k = 0;
    while (done !== 1'b1 && k < 20) begin tick(); k++; end
    n_tests++;
    if (dut_x(2) !== 293 || dut_y(2) !== 55) begin
      n_fail++;
      $display("FAIL load_with_frame got (%0d,%0d) required (293,55)", dut_x(2), dut_y(2));
    end
  endtask

  task automatic test_pause_load_gating();
    int k;
    pause = 1'b1;
    for (int f = 0; f < 3; f++) begin
      frame = 1'b1; tick(); frame = 1'b0; tick();
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_fail++; $display("FAIL pause_flags frame=%0d busy=%b done=%b required 0 0", f, busy, done);
      end
    end
    for (int i = 0; i < SPR_CNT; i++) begin
      n_tests++;
      if (dut_x(i) !== mx[i] || dut_y(i) !== my[i]) begin
        n_fail++;
        $display("FAIL pause_pos spr=%0d got (%0d,%0d) required (%0d,%0d)", i, dut_x(i), dut_y(i), mx[i], my[i]);
      end
    end
    pause = 1'b0;
    frame = 1'b1; tick(); frame = 1'b0; tick();
    ld_idx = 2'd1; ld_x = 16'sd10; ld_y = 16'sd10; ld_vx = 6'sd1; ld_vy = 6'sd1;
    ld_valid = 1'b1;
    n_tests++;
    if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL ld_ready_busy got %b required 0", ld_ready); end
    tick(); tick();
    ld_valid = 1'b0;
    model_frame();
    k = 0;
    while (done !== 1'b1 && k < 20) begin tick(); k++; end
    n_tests++;
    if (dut_x(1) !== mx[1] || dut_y(1) !== my[1]) begin
      n_fail++;
      $display("FAIL load_dropped got (%0d,%0d) required (%0d,%0d)", dut_x(1), dut_y(1), mx[1], my[1]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      for (int l = 0; l < int'($urandom_range(0, 3)); l++) begin
        do_load(int'($urandom_range(0, SPR_CNT - 1)),
                int'($urandom_range(0, 900)) - 150, int'($urandom_range(0, 750)) - 150,
                int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 63)) - 32);
      end
      wrap = 1'($urandom_range(0, 1));
      run_frame();
      for (int i = 0; i < SPR_CNT; i++) begin
        n_tests++;
        if (dut_x(i) !== mx[i] || dut_y(i) !== my[i]) begin
          n_fail++;
          $display("FAIL random it=%0d spr=%0d got (%0d,%0d) required (%0d,%0d)",
                   it, i, dut_x(i), dut_y(i), mx[i], my[i]);
        end
      end
    end
    wrap = 1'b0;
  endtask

  task automatic test_reset_mid_sweep();
    frame = 1'b1; tick(); frame = 1'b0; tick();
    rst_pix = 1'b1;
    tick();
    rst_pix = 1'b0;
    model_reset();
    for (int k = 0; k < 8; k++) begin
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_fail++; $display("FAIL reset_mid_flags cycle=%0d busy=%b done=%b required 0 0", k, busy, done);
      end
      tick();
    end
    for (int i = 0; i < SPR_CNT; i++) begin
      n_tests++;
      if (dut_x(i) !== mx[i] || dut_y(i) !== my[i]) begin
        n_fail++;
        $display("FAIL reset_mid_pos spr=%0d got (%0d,%0d) required (%0d,%0d)", i, dut_x(i), dut_y(i), mx[i], my[i]);
      end
    end
  endtask

  initial begin
`ifdef SPRITE_MOVER_WRAP_EN
    wrap_on = 1'b1;
`else
    wrap_on = 1'b0;
`endif
    rst_pix = 1'b1; frame = 1'b0; pause = 1'b0; wrap = 1'b0; ld_valid = 1'b0;
    ld_idx = '0; ld_x = '0; ld_y = '0; ld_vx = '0; ld_vy = '0;
    test_reset();
    test_sweep_timing();
    test_bounce_right();
    test_left_edge();
    test_load_with_frame();
    test_pause_load_gating();
    test_random();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
